arbiter_mux2_1_2bit: RTL and testbench

//   Round-robin arbiter that shares one 2:1 mux datapath (default 2-bit) between two requesters.
//   It sequences the mux select and registers the winning word into a single output stage.

---
 rtl/arbiter_mux2_1_2bit.sv | 133 +++++++++++++
 tb/tb_arbiter_mux2_1_2bit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_mux2_1_2bit.sv
// arbiter_mux2_1_2bit
//   Round-robin arbiter that shares one 2:1 mux datapath between two requesters.
//   The winning word is registered into a single valid/ready output stage.
//   A hold limit caps back-to-back accepts per requester while the other waits.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_0/1    requester has a word; held with data stable until its ack
//   data_0/1   requester words
//   gnt_0/1    requester owns the mux (decoded from state flops)
//   ack_0/1    combinational: word accepted this cycle
//   sel_mux    mux select, 1 while requester 1 owns the mux
//   out_data   registered output word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer takes out_data when out_valid & out_ready

module arbiter_mux2_1_2bit #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_0,
  input  logic [WIDTH-1:0] data_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] data_1,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             ack_0,
  output logic             ack_1,
  output logic             sel_mux,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic [HOLD_W-1:0] hold_cnt;
  logic              can_load;
  logic              hold_done;
  logic              enter_gnt;
  logic              ack_any;

  // Grant and select come straight from the state flops
  assign gnt_0   = (state == GNT0);
  assign gnt_1   = (state == GNT1);
  assign sel_mux = gnt_1;

  // Output stage can take a new word when empty or draining this cycle
  assign can_load = !out_valid || out_ready;
  assign ack_0    = gnt_0 && req_0 && can_load;
  assign ack_1    = gnt_1 && req_1 && can_load;
  assign ack_any  = ack_0 || ack_1;

  // Counter saturates at the last slot, so the switch fires on the next ack
  // after the other side starts requesting
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign enter_gnt = (state_nxt != state) && (state_nxt != IDLE);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_0 && req_1) begin
          state_nxt = last_grant ? GNT0 : GNT1;
        end else if (req_0) begin
          state_nxt = GNT0;
        end else if (req_1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!req_0) begin
          state_nxt = req_1 ? GNT1 : IDLE;
        end else if (ack_0 && hold_done && req_1) begin
          state_nxt = GNT1;
        end
      end
      GNT1: begin
        if (!req_1) begin
          state_nxt = req_0 ? GNT0 : IDLE;
        end else if (ack_1 && hold_done && req_0) begin
          state_nxt = GNT0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin history and hold counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (enter_gnt) begin
        last_grant <= (state_nxt == GNT1);
        hold_cnt   <= '0;
      end else if (ack_any && !hold_done) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Single output register with valid/ready handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ack_any) begin
      out_valid <= 1'b1;
      out_data  <= sel_mux ? data_1 : data_0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbiter_mux2_1_2bit.sv
// tb_arbiter_mux2_1_2bit
//   Directed scenarios with literal expectations, then randomized traffic,
//   all checked every cycle against an owner/streak model of the arbiter.

module tb_arbiter_mux2_1_2bit;

  localparam int unsigned WIDTH    = 2;
  localparam int unsigned MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_0;
  logic [WIDTH-1:0] data_0;
  logic             req_1;
  logic [WIDTH-1:0] data_1;
  logic             gnt_0;
  logic             gnt_1;
  logic             ack_0;
  logic             ack_1;
  logic             sel_mux;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  always #5 clk = ~clk;

  arbiter_mux2_1_2bit #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_0     (req_0),
    .data_0    (data_0),
    .req_1     (req_1),
    .data_1    (data_1),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .ack_0     (ack_0),
    .ack_1     (ack_1),
    .sel_mux   (sel_mux),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int checks   = 0;
  int failures = 0;

  // Model: owner (-1 none), who was granted last, accepts in current tenure,
  // and the contents of the output stage
  int               m_owner;
  int               m_last;
  int               m_streak;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  bit               m_ack0;
  bit               m_ack1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Compare DUT against the model for this cycle, then advance the model
  task automatic model_cycle();
    bit can;
    bit mine;
    bit other;
    bit acked;
    int nxt;
    int o;
    if (reset) begin
      m_owner  = -1;
      m_last   = 1;
      m_streak = 0;
      m_valid  = 1'b0;
      m_data   = '0;
      m_ack0   = 1'b0;
      m_ack1   = 1'b0;
      chk("rst_gnt_0", 32'(gnt_0), 0);
      chk("rst_gnt_1", 32'(gnt_1), 0);
      chk("rst_ack", 32'(ack_0 | ack_1), 0);
      chk("rst_sel", 32'(sel_mux), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      return;
    end
    can    = !m_valid || out_ready;
    m_ack0 = (m_owner == 0) && req_0 && can;
    m_ack1 = (m_owner == 1) && req_1 && can;
    chk("gnt_0", 32'(gnt_0), 32'(m_owner == 0));
    chk("gnt_1", 32'(gnt_1), 32'(m_owner == 1));
    chk("sel_mux", 32'(sel_mux), 32'(m_owner == 1));
    chk("ack_0", 32'(ack_0), 32'(m_ack0));
    chk("ack_1", 32'(ack_1), 32'(m_ack1));
    chk("ack_excl", 32'(ack_0 & ack_1), 0);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));

    if (m_ack0) begin
      m_valid = 1'b1;
      m_data  = data_0;
    end else if (m_ack1) begin
      m_valid = 1'b1;
      m_data  = data_1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end

    if (m_owner < 0) begin
      if (req_0 && req_1) nxt = 1 - m_last;
      else if (req_0)     nxt = 0;
      else if (req_1)     nxt = 1;
      else                nxt = -1;
    end else begin
      o     = m_owner;
      mine  = (o == 0) ? req_0 : req_1;
      other = (o == 0) ? req_1 : req_0;
      acked = (o == 0) ? m_ack0 : m_ack1;
      if (!mine) nxt = other ? 1 - o : -1;
      else if (acked && other && m_streak >= int'(MAX_HOLD) - 1) nxt = 1 - o;
      else nxt = o;
    end

    if (nxt >= 0 && nxt != m_owner) begin
      m_last   = nxt;
      m_streak = 0;
    end else if (nxt == m_owner && (m_ack0 || m_ack1)) begin
      m_streak++;
    end
    m_owner = nxt;
  endtask

  // One clock: check/advance at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_0     = 1'b0;
    req_1     = 1'b0;
    data_0    = '0;
    data_1    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_0     = 1'b0;
    req_1     = 1'b0;
    data_0    = '0;
    data_1    = '0;
    out_ready = 1'b0;

    // Reset while requester 1 owns the mux and a word is pending
    do_reset();
    req_1  = 1'b1;
    data_1 = 2'b11;
    tick();
    chk("t1_gnt1", 32'(gnt_1), 1);
    tick();
    chk("t1_valid", 32'(out_valid), 1);
    reset  = 1'b1;
    req_0  = 1'b1;
    data_0 = 2'b01;
    #1;
    chk("t1_rst_gnt1", 32'(gnt_1), 0);
    chk("t1_rst_valid", 32'(out_valid), 0);
    chk("t1_rst_data", 32'(out_data), 0);
    chk("t1_rst_ack1", 32'(ack_1), 0);
    chk("t1_rst_sel", 32'(sel_mux), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t1_first_gnt0", 32'(gnt_0), 1);
    chk("t1_first_gnt1", 32'(gnt_1), 0);

    // Single requester streaming three words, then idle return with drain
    do_reset();
    req_0     = 1'b1;
    data_0    = 2'b01;
    out_ready = 1'b1;
    tick();
    chk("t2_gnt0_c1", 32'(gnt_0), 1);
    tick();
    chk("t2_data_c2", 32'(out_data), 32'h1);
    chk("t2_valid_c2", 32'(out_valid), 1);
    data_0 = 2'b10;
    tick();
    chk("t2_data_c3", 32'(out_data), 32'h2);
    data_0 = 2'b11;
    tick();
    chk("t2_data_c4", 32'(out_data), 32'h3);
    chk("t2_valid_c4", 32'(out_valid), 1);
    chk("t2_gnt1_c4", 32'(gnt_1), 0);
    req_0     = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("t6_idle_gnt0", 32'(gnt_0), 0);
    chk("t6_idle_gnt1", 32'(gnt_1), 0);
    chk("t6_idle_sel", 32'(sel_mux), 0);
    chk("t6_held_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("t6_drained", 32'(out_valid), 0);
    chk("t6_data_hold", 32'(out_data), 32'h3);

    // Contention: four accepts each, alternating
    do_reset();
    req_0     = 1'b1;
    req_1     = 1'b1;
    data_0    = 2'b01;
    data_1    = 2'b10;
    out_ready = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("t3_ack0", 32'(ack_0), 32'((((t - 1) / 4) % 2) == 0));
      chk("t3_ack1", 32'(ack_1), 32'((((t - 1) / 4) % 2) == 1));
      chk("t3_sel", 32'(sel_mux), 32'((((t - 1) / 4) % 2) == 1));
    end

    // Backpressure stall then a single-cycle ready
    do_reset();
    req_0  = 1'b1;
    data_0 = 2'b10;
    tick();
    chk("t4_gnt0", 32'(gnt_0), 1);
    chk("t4_ack_first", 32'(ack_0), 1);
    tick();
    data_0 = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_stall_ack", 32'(ack_0), 0);
      chk("t4_stall_data", 32'(out_data), 32'h2);
      chk("t4_stall_valid", 32'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_one_ack", 32'(ack_0), 1);
    tick();
    out_ready = 1'b0;
    data_0    = 2'b11;
    #1;
    chk("t4_new_word", 32'(out_data), 32'h1);
    chk("t4_no_ack", 32'(ack_0), 0);
    tick();
    tick();
    chk("t4_still_word", 32'(out_data), 32'h1);

    // Release handover with hold counter restart
    do_reset();
    req_0     = 1'b1;
    data_0    = 2'b10;
    out_ready = 1'b1;
    tick();
    tick();
    req_0  = 1'b0;
    req_1  = 1'b1;
    data_1 = 2'b01;
    #1;
    chk("t5_no_ack0", 32'(ack_0), 0);
    tick();
    chk("t5_gnt1", 32'(gnt_1), 1);
    chk("t5_gnt0", 32'(gnt_0), 0);
    req_0 = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_ack1_run", 32'(ack_1), 1);
      chk("t5_ack0_run", 32'(ack_0), 0);
      tick();
    end
    chk("t5_back_gnt0", 32'(gnt_0), 1);
    chk("t5_back_ack0", 32'(ack_0), 1);

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      if (req_0 && m_ack0) begin
        if ($urandom_range(0, 9) < 7) data_0 = WIDTH'($urandom);
        else req_0 = 1'b0;
      end else if (!req_0 && $urandom_range(0, 9) < 4) begin
        req_0  = 1'b1;
        data_0 = WIDTH'($urandom);
      end
      if (req_1 && m_ack1) begin
        if ($urandom_range(0, 9) < 7) data_1 = WIDTH'($urandom);
        else req_1 = 1'b0;
      end else if (!req_1 && $urandom_range(0, 9) < 4) begin
        req_1  = 1'b1;
        data_1 = WIDTH'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
